// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage between the program counter and decode.
// Drives the combinational code ROM from the PC. Captures the returned word into
// a single output slot with a valid/ready handshake. Follows control-flow
// redirects, and stops fetching after a misaligned-address fault until the next
// redirect.
module fetch_stage #(
    parameter int unsigned            ADDR_WIDTH = 64,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  rom_illegal_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_fault_o,
    output logic [63:0]           fetch_count_o
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  fault_q, fault_d;
    logic [63:0]           count_q, count_d;

    logic                  load;
    logic                  handshake;

    // The slot can accept a new word when it is empty or is being drained this cycle.
    assign load      = !valid_q || inst_ready_i;
    assign handshake = valid_q && inst_ready_i;

    // Next-state logic: redirect overrides fetch; a faulting fetch parks the FSM in HALT.
    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path through
        // the case/if tree leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        // A handshake that coincides with a redirect is still counted.
        count_d   = count_q + {63'd0, handshake};

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            valid_d = 1'b0;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load) begin
                        valid_d   = 1'b1;
                        inst_d    = rom_data_i;
                        inst_pc_d = pc_q;
                        fault_d   = rom_illegal_i;
                        if (rom_illegal_i) begin
                            state_d = HALT;
                        end else begin
                            // Wraps silently from the top of the address space to zero.
                            pc_d = pc_q + ADDR_WIDTH'(4);
                        end
                    end
                end
                HALT: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register with synchronous reset; reset takes priority over any redirect.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments, so every register
        // samples the values from before this edge, whatever the statement order.
        if (rst_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
        end
    end

    // All outputs come straight from registers; no input reaches an output combinationally.
    assign rom_addr_o    = pc_q;
    assign inst_valid_o  = valid_q;
    assign inst_o        = inst_q;
    assign inst_pc_o     = inst_pc_q;
    assign inst_fault_o  = fault_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus for fetch_stage. Expected handshakes go into a
// scoreboard queue, and an independent monitor checks each one as decode accepts it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        rom_illegal_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_fault_o;
    logic [63:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(32),
        .RESET_PC  (64'h0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .rom_addr_o      (rom_addr_o),
        .rom_data_i      (rom_data_i),
        .rom_illegal_i   (rom_illegal_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_fault_o    (inst_fault_o),
        .fetch_count_o   (fetch_count_o)
    );

    // Code ROM: 0x13 (nop) in words 0..3, an address tag elsewhere, and a fault returning 0 when misaligned.
    always_comb begin
        rom_illegal_i = (rom_addr_o[1:0] != 2'b00);
        if (rom_illegal_i)          rom_data_i = 32'h0;
        else if (rom_addr_o < 64'd16) rom_data_i = 32'h0000_0013;
        else                        rom_data_i = 32'hC000_0000 | {4'h0, rom_addr_o[27:0]};
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [63:0] pc, input logic fault);
        sb.push_back('{inst: inst, pc: pc, fault: fault});
    endtask

    // Monitor: every accepted slot must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_i && inst_valid_o && inst_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_handshake_pc", inst_pc_o, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hs_inst",  {32'h0, inst_o},       {32'h0, e.inst});
                check("hs_pc",    inst_pc_o,             e.pc);
                check("hs_fault", {63'h0, inst_fault_o}, {63'h0, e.fault});
            end
        end
    end

    initial begin
        rst_i            = 1'b1;
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 64'h0;

        // Reset state.
        tick();
        tick();
        check("rst_valid", {63'h0, inst_valid_o}, 64'h0);
        check("rst_count", fetch_count_o, 64'h0);
        check("rst_addr",  rom_addr_o,    64'h0);
        check("rst_inst",  {32'h0, inst_o}, 64'h0);
        check("rst_pc",    inst_pc_o,     64'h0);
        check("rst_fault", {63'h0, inst_fault_o}, 64'h0);

        // First fetch with decode stalled; the slot and PC must hold.
        rst_i = 1'b0;
        tick();
        check("first_valid", {63'h0, inst_valid_o}, 64'h1);
        check("first_pc",    inst_pc_o,  64'h0);
        check("first_addr",  rom_addr_o, 64'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {63'h0, inst_valid_o}, 64'h1);
            check("stall_inst",  {32'h0, inst_o}, 64'h13);
            check("stall_pc",    inst_pc_o,  64'h0);
            check("stall_addr",  rom_addr_o, 64'h4);
            check("stall_count", fetch_count_o, 64'h0);
        end

        // Release: one instruction per cycle at sequential PCs.
        push(32'h13, 64'h0, 1'b0);
        push(32'h13, 64'h4, 1'b0);
        push(32'h13, 64'h8, 1'b0);
        push(32'h13, 64'hC, 1'b0);
        inst_ready_i = 1'b1;
        tick();
        check("resume_pc", inst_pc_o, 64'h4);
        tick();
        tick();
        tick();
        check("count_after_4", fetch_count_o, 64'h4);
        check("held_pc16",     inst_pc_o,     64'h10);

        // Redirect while the slot holds an unaccepted word: the slot is flushed.
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h40;
        tick();
        redirect_valid_i = 1'b0;
        check("redir_flush_valid", {63'h0, inst_valid_o}, 64'h0);
        check("redir_addr",        rom_addr_o,    64'h40);
        check("redir_count",       fetch_count_o, 64'h4);
        push(32'hC000_0040, 64'h40, 1'b0);
        push(32'hC000_0044, 64'h44, 1'b0);
        inst_ready_i = 1'b1;
        tick();
        check("redir_target_pc", inst_pc_o, 64'h40);
        tick();

        // Redirect to a misaligned target while a handshake completes in the same cycle.
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h42;
        tick();
        redirect_valid_i = 1'b0;
        inst_ready_i     = 1'b0;
        check("redir_hs_count", fetch_count_o, 64'h6);
        check("redir_hs_valid", {63'h0, inst_valid_o}, 64'h0);
        tick();
        check("fault_valid", {63'h0, inst_valid_o}, 64'h1);
        check("fault_flag",  {63'h0, inst_fault_o}, 64'h1);
        check("fault_inst",  {32'h0, inst_o}, 64'h0);
        check("fault_pc",    inst_pc_o,  64'h42);
        check("fault_addr",  rom_addr_o, 64'h42);
        push(32'h0, 64'h42, 1'b1);
        inst_ready_i = 1'b1;
        tick();
        check("halt_drain_valid", {63'h0, inst_valid_o}, 64'h0);
        check("halt_addr",        rom_addr_o, 64'h42);
        tick();
        check("halt_stays_empty", {63'h0, inst_valid_o}, 64'h0);
        check("halt_count",       fetch_count_o, 64'h7);

        // Redirect out of HALT.
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h80;
        tick();
        redirect_valid_i = 1'b0;
        push(32'hC000_0080, 64'h80, 1'b0);
        tick();
        check("resume_80_pc", inst_pc_o, 64'h80);

        // PC wrap from the top of the address space to zero.
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        push(32'hCFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(32'h13, 64'h0, 1'b0);
        tick();
        check("wrap_addr", rom_addr_o, 64'h0);
        tick();
        check("wrap_pc",    inst_pc_o, 64'h0);
        check("wrap_fault", {63'h0, inst_fault_o}, 64'h0);
        tick();
        check("pre_rst_count", fetch_count_o, 64'hA);
        check("pre_rst_valid", {63'h0, inst_valid_o}, 64'h1);

        // Reset mid-stream; a simultaneous redirect must be ignored.
        rst_i            = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h200;
        tick();
        rst_i            = 1'b0;
        redirect_valid_i = 1'b0;
        check("midrst_valid", {63'h0, inst_valid_o}, 64'h0);
        check("midrst_count", fetch_count_o, 64'h0);
        check("midrst_addr",  rom_addr_o,    64'h0);
        push(32'h13, 64'h0, 1'b0);
        tick();
        check("post_rst_valid", {63'h0, inst_valid_o}, 64'h1);
        check("post_rst_pc",    inst_pc_o, 64'h0);
        tick();
        inst_ready_i = 1'b0;
        check("post_rst_count", fetch_count_o, 64'h1);
        tick();
        tick();
        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
